// File: rtl/route_input_conditioner.sv
// Probe front end: per-route synchronizer, glitch filter and edge/level
// selector driving the shared route bus, with a byte-wide config port.
module route_input_conditioner #(
   parameter int NUM_ROUTES = 16,
   parameter int ADR_WIDTH  = 4
) (
   input  logic                  ctrclk,
   input  logic                  ctrrst_n,
   input  logic [NUM_ROUTES-1:0] probe_in,
   output logic [NUM_ROUTES-1:0] route_out,
   input  logic [7:0]            data_in,
   output logic [7:0]            data_out,
   input  logic [ADR_WIDTH-1:0]  adr,
   input  logic                  cs,
   input  logic                  rd,
   input  logic                  wr
);

   logic [NUM_ROUTES-1:0] s1;
   logic [NUM_ROUTES-1:0] s2;
   logic [NUM_ROUTES-1:0] filt;
   logic [3:0]            cnt [NUM_ROUTES];
   logic [7:0]            cfg [NUM_ROUTES];
   logic                  wr_q;

   logic [NUM_ROUTES-1:0] diff;
   logic [NUM_ROUTES-1:0] commit;
   logic [NUM_ROUTES-1:0] filt_nx;
   logic [NUM_ROUTES-1:0] hit;
   logic                  adr_ok;
   logic                  we;

   assign adr_ok = int'(adr) < NUM_ROUTES;
   assign we     = wr && cs && !wr_q && adr_ok;

   // Level mode uses the next filt value so both modes share one latency.
   always_comb begin
      for (int i = 0; i < NUM_ROUTES; i++) begin
         diff[i]    = s2[i] ^ filt[i];
         commit[i]  = diff[i] && (cnt[i] >= cfg[i][7:4]);
         filt_nx[i] = commit[i] ? s2[i] : filt[i];
         if (cfg[i][2]) begin
            hit[i] = filt_nx[i];
         end else begin
            hit[i] = commit[i] &&
                     ((s2[i] && cfg[i][0]) ||
                      (!s2[i] && cfg[i][1]));
         end
      end
   end

   always_comb begin
      data_out = 8'hff;
      if (rd && cs && adr_ok) begin
         data_out = (cfg[adr] & 8'hf7) |
                    {4'b0, filt[adr], 3'b0};
      end
   end

   always_ff @(posedge ctrclk or negedge ctrrst_n) begin
      if (!ctrrst_n) begin
         s1        <= '0;
         s2        <= '0;
         filt      <= '0;
         route_out <= '0;
         wr_q      <= 1'b0;
         for (int i = 0; i < NUM_ROUTES; i++) begin
            cnt[i] <= 4'd0;
            cfg[i] <= 8'd0;
         end
      end else begin
         s1        <= probe_in;
         s2        <= s1;
         filt      <= filt_nx;
         route_out <= hit;
         wr_q      <= wr && cs;
         for (int i = 0; i < NUM_ROUTES; i++) begin
            if (!diff[i] || commit[i]) begin
               cnt[i] <= 4'd0;
            end else if (cnt[i] != 4'd15) begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
         if (we) begin
            cfg[adr] <= data_in & 8'hf7;
         end
      end
   end

endmodule

// File: tb/tb_route_input_conditioner.sv
// Scoreboard bench: stimulus queues expected route pulses and read data,
// a negedge monitor pops and compares whenever the DUT presents output.
module tb_route_input_conditioner;

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } pulse_t;

   logic        ctrclk;
   logic        ctrrst_n;
   logic [15:0] probe_in;
   logic [15:0] route_out;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [3:0]  adr;
   logic        cs;
   logic        rd;
   logic        wr;

   logic [11:0] b_probe;
   logic [11:0] b_route;
   logic [7:0]  b_data_in;
   logic [7:0]  b_data_out;
   logic [3:0]  b_adr;
   logic        b_cs;
   logic        b_rd;
   logic        b_wr;

   int          cyc;
   int          checks;
   int          errors;
   int          c;
   pulse_t      exp_q[$];
   logic [7:0]  rd_q[$];

   route_input_conditioner #(
      .NUM_ROUTES(16),
      .ADR_WIDTH (4)
   ) u_dut (
      .ctrclk   (ctrclk),
      .ctrrst_n (ctrrst_n),
      .probe_in (probe_in),
      .route_out(route_out),
      .data_in  (data_in),
      .data_out (data_out),
      .adr      (adr),
      .cs       (cs),
      .rd       (rd),
      .wr       (wr)
   );

   route_input_conditioner #(
      .NUM_ROUTES(12),
      .ADR_WIDTH (4)
   ) u_dut12 (
      .ctrclk   (ctrclk),
      .ctrrst_n (ctrrst_n),
      .probe_in (b_probe),
      .route_out(b_route),
      .data_in  (b_data_in),
      .data_out (b_data_out),
      .adr      (b_adr),
      .cs       (b_cs),
      .rd       (b_rd),
      .wr       (b_wr)
   );

   initial begin
      ctrclk = 1'b0;
      forever #5 ctrclk = ~ctrclk;
   end

   initial cyc = 0;
   always @(posedge ctrclk) cyc <= cyc + 1;

   always @(negedge ctrclk) begin
      pulse_t     p;
      logic [7:0] r;
      if (ctrrst_n && route_out != 16'h0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse: route_out=%h at cycle %0d, required 0000",
                     route_out, cyc);
         end else begin
            p = exp_q.pop_front();
            if (p.cyc != cyc || p.val !== route_out) begin
               errors++;
               $display("FAIL pulse: got %h at cycle %0d, required %h at %0d",
                        route_out, cyc, p.val, p.cyc);
            end
         end
      end
      if (rd && cs) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL read: unexpected read data %h", data_out);
         end else begin
            r = rd_q.pop_front();
            if (data_out !== r) begin
               errors++;
               $display("FAIL read adr %0d: got %h, required %h",
                        adr, data_out, r);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ctrclk);
         #1;
      end
   endtask

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
      adr     = a;
      data_in = d;
      cs      = 1'b1;
      wr      = 1'b1;
      tick(1);
      wr = 1'b0;
      cs = 1'b0;
      tick(1);
   endtask

   task automatic do_read(input logic [3:0] a, input logic [7:0] e);
      adr = a;
      cs  = 1'b1;
      rd  = 1'b1;
      rd_q.push_back(e);
      tick(1);
      rd = 1'b0;
      cs = 1'b0;
   endtask

   task automatic push(input int at, input logic [15:0] v);
      pulse_t p;
      p.cyc = at;
      p.val = v;
      exp_q.push_back(p);
   endtask

   task automatic b_write(input logic [3:0] a, input logic [7:0] d);
      b_adr     = a;
      b_data_in = d;
      b_cs      = 1'b1;
      b_wr      = 1'b1;
      tick(1);
      b_wr = 1'b0;
      b_cs = 1'b0;
      tick(1);
   endtask

   task automatic b_read(input logic [3:0] a, input logic [7:0] e);
      b_adr = a;
      b_cs  = 1'b1;
      b_rd  = 1'b1;
      #1;
      check($sformatf("dut12_read_%0d", a), {8'h0, b_data_out}, {8'h0, e});
      b_rd = 1'b0;
      b_cs = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      ctrrst_n  = 1'b0;
      probe_in  = '0;
      data_in   = '0;
      adr       = '0;
      cs        = 1'b0;
      rd        = 1'b0;
      wr        = 1'b0;
      b_probe   = '0;
      b_data_in = '0;
      b_adr     = '0;
      b_cs      = 1'b0;
      b_rd      = 1'b0;
      b_wr      = 1'b0;
      tick(2);
      check("reset_route", route_out, 16'h0);
      ctrrst_n = 1'b1;
      tick(2);
      do_read(4'd0, 8'h00);

      // rising pulse, flen 0, then falling gives nothing
      cfg_write(4'd0, 8'h01);
      c = cyc;
      probe_in[0] = 1'b1;
      push(c + 3, 16'h0001);
      tick(10);
      probe_in[0] = 1'b0;
      tick(10);

      // glitch filter, both edges, flen 5
      cfg_write(4'd3, 8'h53);
      probe_in[3] = 1'b1;
      tick(5);
      probe_in[3] = 1'b0;
      tick(4);
      do_read(4'd3, 8'h53);
      tick(2);
      c = cyc;
      probe_in[3] = 1'b1;
      push(c + 8, 16'h0008);
      tick(6);
      probe_in[3] = 1'b0;
      c = cyc;
      push(c + 8, 16'h0008);
      tick(12);

      // level mode
      cfg_write(4'd7, 8'h04);
      c = cyc;
      probe_in[7] = 1'b1;
      for (int i = 3; i <= 8; i++) push(c + i, 16'h0080);
      tick(4);
      do_read(4'd7, 8'h0c);
      tick(1);
      probe_in[7] = 1'b0;
      tick(8);

      // write edge detect and reserved bit
      adr     = 4'd15;
      data_in = 8'h01;
      cs      = 1'b1;
      wr      = 1'b1;
      tick(2);
      data_in = 8'h02;
      tick(2);
      wr = 1'b0;
      cs = 1'b0;
      tick(1);
      do_read(4'd15, 8'h01);
      cfg_write(4'd14, 8'hf8);
      do_read(4'd14, 8'hf0);
      adr = 4'd14;
      rd  = 1'b1;
      #1;
      check("read_no_cs", {8'h0, data_out}, 16'h00ff);
      rd = 1'b0;
      tick(1);

      // out-of-range address on a 12-route instance
      b_write(4'd11, 8'h2a);
      b_read(4'd11, 8'h22);
      b_write(4'd13, 8'h31);
      b_read(4'd13, 8'hff);

      // mode change alone gives no pulse
      probe_in[2] = 1'b1;
      tick(6);
      cfg_write(4'd2, 8'h01);
      tick(5);
      probe_in[2] = 1'b0;
      tick(6);
      c = cyc;
      probe_in[2] = 1'b1;
      push(c + 3, 16'h0004);
      tick(8);

      // async reset mid-pulse and mid-count
      probe_in[0] = 1'b1;
      probe_in[3] = 1'b1;
      tick(3);
      check("pre_reset_pulse", route_out, 16'h0001);
      #1;
      ctrrst_n = 1'b0;
      #1;
      check("async_reset_route", route_out, 16'h0);
      adr = 4'd0;
      cs  = 1'b1;
      rd  = 1'b1;
      #1;
      check("async_reset_rd0", {8'h0, data_out}, 16'h0);
      adr = 4'd3;
      rd_q.push_back(8'h00);
      probe_in = '1;
      tick(1);
      rd = 1'b0;
      cs = 1'b0;
      tick(2);
      ctrrst_n = 1'b1;
      tick(20);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: %0d left, required 0", exp_q.size());
      end
      checks++;
      if (rd_q.size() != 0) begin
         errors++;
         $display("FAIL missing_reads: %0d left, required 0", rd_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
